// File: rtl/decoder8_strobe_pkg.sv
// Shared constants, state encoding and sizing helper for the registered 3-to-8 strobe decoder.
// CODE_NONE must match the value the upstream priority encoder emits for "nothing detected".
package decoder8_strobe_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 8;

    localparam logic [CODE_W-1:0] CODE_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/decoder8_strobe_if.sv
// Code handshake plus strobe/status outputs of the strobe decoder.
// master = code source, slave = decoder8_strobe.
interface decoder8_strobe_if;
    import decoder8_strobe_pkg::*;

    logic [CODE_W-1:0] in;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out;
    logic              busy;
    logic              err;

    modport master (output in, in_valid, input in_ready, out, busy, err);
    modport slave  (input in, in_valid, output in_ready, out, busy, err);

endinterface

// File: rtl/decoder8_strobe_timer.sv
// Loadable down-counter shared by the hold and gap phases; done is high while the count is zero.
// The count saturates at zero so an idle timer never wraps.
module decoder8_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/decoder8_strobe.sv
// Registered 3-to-8 decoder: an accepted code 0..7 drives one OUT line for HOLD_CYCLES,
// then OUT is forced low for GAP_CYCLES before the next code can be accepted.
module decoder8_strobe
    import decoder8_strobe_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    decoder8_strobe_if.slave    bus
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);
    localparam int TMR_W  = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;

    localparam int HOLD_LOAD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int GAP_LOAD_I  = (GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_LOAD_I);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_LOAD_I);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("decoder8_strobe: HOLD_CYCLES must be 1..255");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
            $error("decoder8_strobe: GAP_CYCLES must be 0..15");
        end
    endgenerate

    state_e            state, state_nxt;
    logic [OUT_W-1:0]  out_q, out_nxt;
    logic              busy_q, busy_nxt;
    logic              err_q, err_nxt;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_done;
    logic              xfer;

    assign bus.in_ready = (state == ST_IDLE);
    assign xfer         = bus.in_valid && bus.in_ready;

    decoder8_strobe_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        out_nxt   = out_q;
        busy_nxt  = busy_q;
        err_nxt   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = HOLD_LOAD;

        case (state)
            ST_IDLE: begin
                out_nxt  = '0;
                busy_nxt = 1'b0;
                if (xfer) begin
                    if (!bus.in[CODE_W-1]) begin
                        state_nxt = ST_DRIVE;
                        out_nxt   = OUT_W'(1) << bus.in[2:0];
                        busy_nxt  = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = HOLD_LOAD;
                    end else if (bus.in != CODE_NONE) begin
                        err_nxt = 1'b1;
                    end
                end
            end

            ST_DRIVE: begin
                if (tmr_done) begin
                    out_nxt = '0;
                    if (GAP_CYCLES > 0) begin
                        state_nxt = ST_GAP;
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                out_nxt = '0;
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                out_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            out_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            out_q  <= out_nxt;
            busy_q <= busy_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_decoder8_strobe.sv
// Bench for decoder8_strobe: a timeline model (accept edge + elapsed cycles) checked every cycle,
// plus directed scenarios with literal expectations.
module tb_decoder8_strobe;
    import decoder8_strobe_pkg::*;

    localparam int H = 4;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   started = 1'b0;

    decoder8_strobe_if bus ();

    decoder8_strobe #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Free-running edge index used to timestamp accepts in the directed tests.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Timeline model: remembers the last accepted code and the edge it was accepted on;
    // outputs follow from elapsed cycles since that edge.
    int         cur       = 0;
    int         free_at   = 0;
    int         acc_edge  = 0;
    logic       acc_valid = 1'b0;
    logic [3:0] acc_code  = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= 0;
            free_at   <= 0;
            acc_valid <= 1'b0;
        end else begin
            cur <= cur + 1;
            if (bus.in_valid === 1'b1 && cur >= free_at) begin
                acc_valid <= 1'b1;
                acc_code  <= bus.in;
                acc_edge  <= cur + 1;
                free_at   <= (bus.in < 4'd8) ? cur + 1 + H + G : cur + 1;
            end
        end
    end

    function automatic logic [7:0] exp_out();
        int d = cur - acc_edge;
        if (acc_valid && acc_code < 4'd8 && d >= 0 && d < H) return 8'd1 << acc_code[2:0];
        return 8'h00;
    endfunction

    function automatic logic exp_busy();
        int d = cur - acc_edge;
        return acc_valid && acc_code < 4'd8 && d >= 0 && d < H + G;
    endfunction

    function automatic logic exp_err();
        return acc_valid && acc_code >= 4'd8 && acc_code != 4'hF && cur == acc_edge;
    endfunction

    function automatic logic [3:0] enc8(input logic [7:0] v);
        logic [3:0] r = 4'hF;
        for (int i = 0; i < 8; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("out",      bus.out,      exp_out());
            check("busy",     bus.busy,     exp_busy());
            check("err",      bus.err,      exp_err());
            check("in_ready", bus.in_ready, cur >= free_at);
            check("onehot",   $countones(bus.out) <= 1, 1);
        end
    end

    // Call at a negedge; returns at the negedge after the accept edge with valid dropped.
    task automatic send(input logic [3:0] c, output int acc);
        bit ok = 1'b0;
        acc = -1;
        bus.in       = c;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = edge_cnt;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n3, n7;
        logic [3:0] c;

        bus.in       = 4'h0;
        bus.in_valid = 1'b0;

        // Reset state, during and after reset.
        #1 rst = 1'b1;
        started = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out",   bus.out,      8'h00);
        check("rst_busy",  bus.busy,     0);
        check("rst_ready", bus.in_ready, 1);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_out",   bus.out,      8'h00);
        check("post_rst_err",   bus.err,      0);
        check("post_rst_ready", bus.in_ready, 1);

        // Code 5: four strobe cycles, one gap cycle, then ready again.
        send(4'd5, n);
        for (int k = 0; k < 4; k++) begin
            check("t2_out",   bus.out,      8'h20);
            check("t2_busy",  bus.busy,     1);
            check("t2_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        check("t2_gap_out",   bus.out,      8'h00);
        check("t2_gap_busy",  bus.busy,     1);
        check("t2_gap_ready", bus.in_ready, 0);
        @(negedge clk);
        check("t2_idle_ready", bus.in_ready, 1);
        check("t2_idle_busy",  bus.busy,     0);

        // "Nothing detected" is a silent no-op.
        send(4'hF, n);
        check("t3_out",   bus.out,      8'h00);
        check("t3_err",   bus.err,      0);
        check("t3_busy",  bus.busy,     0);
        check("t3_ready", bus.in_ready, 1);

        // Illegal code: single-cycle error pulse.
        send(4'd9, n);
        check("t4_err",   bus.err,      1);
        check("t4_out",   bus.out,      8'h00);
        check("t4_ready", bus.in_ready, 1);
        @(negedge clk);
        check("t4_err_gone", bus.err, 0);

        // Back-to-back codes: 7 waits until the 3 strobe and gap are over.
        send(4'd3, n3);
        check("t5_out3", bus.out, 8'h08);
        send(4'd7, n7);
        check("t5_spacing", n7 - n3, 6);
        check("t5_out7",    bus.out, 8'h80);
        repeat (6) @(negedge clk);

        // Asynchronous reset in the middle of a strobe.
        send(4'd2, n);
        @(negedge clk);
        check("t6_out_before", bus.out, 8'h04);
        #2 rst = 1'b1;
        #1;
        check("t6_out_async",  bus.out,  8'h00);
        check("t6_busy_async", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after", bus.in_ready, 1);
        check("t6_out_after",   bus.out,      8'h00);

        // Mixed codes with random idle spacing; the model checks every cycle.
        for (int i = 0; i < 24; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 8)       c = 4'(r);
            else if (r == 8) c = 4'hF;
            else             c = 4'(8 + $urandom_range(0, 6));
            send(c, n);
            if (c < 4'd8) check("rand_enc", enc8(bus.out), c);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
